regfile_wb_arbiter: RTL and testbench

//  Write-back scheduler for the register file's single write port. Arbitrates between the ALU result

---
 rtl/regfile_wb_arbiter_if.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back arbiter and its ALU, load-return, issue and register-file neighbours.
// REGWB_STALL_CNT_EN adds the StallCount observation output.
interface regfile_wb_arbiter_if #(
    parameter int W = 8,
    parameter int D = 4
);
    logic              AluValid;
    logic [D-1:0]      AluAddr;
    logic [W-1:0]      AluData;
    logic              AluReady;
    logic              MemValid;
    logic [D-1:0]      MemAddr;
    logic [W-1:0]      MemData;
    logic              MemReady;
    logic              ClaimValid;
    logic [D-1:0]      ClaimAddr;
    logic              WriteEn;
    logic [D-1:0]      WriteAddr;
    logic [W-1:0]      WriteData;
    logic [(1<<D)-1:0] BusyVec;
`ifdef REGWB_STALL_CNT_EN
    logic [15:0]       StallCount;

    modport master (
        output AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, ClaimValid, ClaimAddr,
        input  AluReady, MemReady, WriteEn, WriteAddr, WriteData, BusyVec, StallCount
    );
    modport slave (
        input  AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, ClaimValid, ClaimAddr,
        output AluReady, MemReady, WriteEn, WriteAddr, WriteData, BusyVec, StallCount
    );
`else
    modport master (
        output AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, ClaimValid, ClaimAddr,
        input  AluReady, MemReady, WriteEn, WriteAddr, WriteData, BusyVec
    );
    modport slave (
        input  AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, ClaimValid, ClaimAddr,
        output AluReady, MemReady, WriteEn, WriteAddr, WriteData, BusyVec
    );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back scheduler: ALU vs buffered load-return arbitration, one registered write
// per cycle, plus a pending-write scoreboard. REGWB_STALL_CNT_EN enables the ALU stall counter.
module regfile_wb_arbiter #(
    parameter int W          = 8,
    parameter int D          = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NREG = 1 << D;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [D-1:0]    r_fifo_addr [FIFO_DEPTH];
    logic [W-1:0]    r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_last_mem;
    logic            r_we_p1;
    logic [D-1:0]    r_waddr_p1;
    logic [W-1:0]    r_wdata_p1;
    logic [NREG-1:0] r_busy;

    logic            w_mem_ready;
    logic            w_push;
    logic            w_fifo_ne;
    logic            w_fifo_full;
    logic            w_gnt_alu;
    logic            w_gnt_mem;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign w_mem_ready = (r_count < FULL_CNT);
    assign w_push      = bus.MemValid & w_mem_ready;
    assign w_fifo_ne   = (r_count != '0);
    assign w_fifo_full = (r_count == FULL_CNT);

    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_mem = 1'b0;
        if (bus.AluValid && w_fifo_ne) begin
            if (w_fifo_full || !r_last_mem) w_gnt_mem = 1'b1;
            else                            w_gnt_alu = 1'b1;
        end else begin
            w_gnt_alu = bus.AluValid;
            w_gnt_mem = w_fifo_ne;
        end
    end

    assign w_set = bus.ClaimValid ? (NREG'(1) << bus.ClaimAddr) : '0;
    assign w_clr = r_we_p1 ? (NREG'(1) << r_waddr_p1) : '0;

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_fifo_addr[r_tail] <= bus.MemAddr;
            r_fifo_data[r_tail] <= bus.MemData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_last_mem <= 1'b1;
            r_we_p1    <= 1'b0;
            r_waddr_p1 <= '0;
            r_wdata_p1 <= '0;
            r_busy     <= '0;
        end else begin
            if (w_push)    r_tail <= ptr_inc(r_tail);
            if (w_gnt_mem) r_head <= ptr_inc(r_head);
            r_count <= r_count + CW'(w_push) - CW'(w_gnt_mem);
            if (w_gnt_alu | w_gnt_mem) r_last_mem <= w_gnt_mem;
            // Write stage: address/data hold when nothing is granted.
            r_we_p1 <= w_gnt_alu | w_gnt_mem;
            if (w_gnt_alu) begin
                r_waddr_p1 <= bus.AluAddr;
                r_wdata_p1 <= bus.AluData;
            end else if (w_gnt_mem) begin
                r_waddr_p1 <= r_fifo_addr[r_head];
                r_wdata_p1 <= r_fifo_data[r_head];
            end
            // A claim landing on the register being retired must stay pending.
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

`ifdef REGWB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge Clk) begin
        if (Reset)
            r_stall_cnt <= '0;
        else if (bus.AluValid && !w_gnt_alu && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign bus.StallCount = r_stall_cnt;
`endif

    assign bus.AluReady  = w_gnt_alu;
    assign bus.MemReady  = w_mem_ready;
    assign bus.WriteEn   = r_we_p1;
    assign bus.WriteAddr = r_waddr_p1;
    assign bus.WriteData = r_wdata_p1;
    assign bus.BusyVec   = r_busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle vector table plus hand-written reset-in-flight sequence.
// With REGWB_STALL_CNT_EN defined the stall counter is also checked.
module tb_regfile_wb_arbiter;
    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    regfile_wb_arbiter_if #(.W(8), .D(4)) bus ();

    regfile_wb_arbiter #(.W(8), .D(4), .FIFO_DEPTH(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        av;
        logic [3:0]  aa;
        logic [7:0]  ad;
        logic        mv;
        logic [3:0]  ma;
        logic [7:0]  md;
        logic        cv;
        logic [3:0]  ca;
        logic        ear;
        logic        emr;
        logic        ewe;
        logic [3:0]  ewa;
        logic [7:0]  ewd;
        logic [15:0] ebusy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic av, input logic [3:0] aa, input logic [7:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [7:0] md,
                       input logic cv, input logic [3:0] ca,
                       input logic ear, input logic emr,
                       input logic ewe, input logic [3:0] ewa, input logic [7:0] ewd,
                       input logic [15:0] ebusy);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv; v.ma = ma; v.md = md;
        v.cv = cv; v.ca = ca;
        v.ear = ear; v.emr = emr;
        v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.ebusy = ebusy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [7:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [7:0] md,
                         input logic cv, input logic [3:0] ca);
        bus.AluValid   = av;
        bus.AluAddr    = aa;
        bus.AluData    = ad;
        bus.MemValid   = mv;
        bus.MemAddr    = ma;
        bus.MemData    = md;
        bus.ClaimValid = cv;
        bus.ClaimAddr  = ca;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        //   av aa  ad     mv ma  md     cv ca  ar mr  we wa  wd     busy
        add(1, 3,  8'h5A, 0, 0,  8'h00, 0, 0,  1, 1,  1, 3,  8'h5A, 16'h0000);
        add(0, 0,  8'h00, 0, 0,  8'h00, 0, 0,  0, 1,  0, 3,  8'h5A, 16'h0000);
        add(0, 0,  8'h00, 1, 1,  8'h11, 0, 0,  0, 1,  0, 3,  8'h5A, 16'h0000);
        add(0, 0,  8'h00, 1, 2,  8'h22, 0, 0,  0, 1,  1, 1,  8'h11, 16'h0000);
        add(0, 0,  8'h00, 1, 4,  8'h44, 0, 0,  0, 1,  1, 2,  8'h22, 16'h0000);
        add(0, 0,  8'h00, 0, 0,  8'h00, 0, 0,  0, 1,  1, 4,  8'h44, 16'h0000);
        add(0, 0,  8'h00, 0, 0,  8'h00, 0, 0,  0, 1,  0, 4,  8'h44, 16'h0000);
        add(0, 0,  8'h00, 1, 6,  8'h60, 0, 0,  0, 1,  0, 4,  8'h44, 16'h0000);
        add(1, 7,  8'h70, 1, 8,  8'h80, 0, 0,  1, 1,  1, 7,  8'h70, 16'h0000);
        add(1, 9,  8'h90, 1, 10, 8'hA0, 0, 0,  0, 0,  1, 6,  8'h60, 16'h0000);
        add(1, 9,  8'h90, 1, 10, 8'hA0, 0, 0,  1, 1,  1, 9,  8'h90, 16'h0000);
        add(1, 11, 8'hB0, 0, 0,  8'h00, 0, 0,  0, 0,  1, 8,  8'h80, 16'h0000);
        add(1, 11, 8'hB0, 0, 0,  8'h00, 0, 0,  1, 1,  1, 11, 8'hB0, 16'h0000);
        add(1, 12, 8'hC0, 0, 0,  8'h00, 0, 0,  0, 1,  1, 10, 8'hA0, 16'h0000);
        add(1, 12, 8'hC0, 0, 0,  8'h00, 0, 0,  1, 1,  1, 12, 8'hC0, 16'h0000);
        add(0, 0,  8'h00, 0, 0,  8'h00, 0, 0,  0, 1,  0, 12, 8'hC0, 16'h0000);
        add(0, 0,  8'h00, 0, 0,  8'h00, 1, 5,  0, 1,  0, 12, 8'hC0, 16'h0020);
        add(1, 5,  8'h55, 0, 0,  8'h00, 0, 0,  1, 1,  1, 5,  8'h55, 16'h0020);
        add(0, 0,  8'h00, 0, 0,  8'h00, 1, 5,  0, 1,  0, 5,  8'h55, 16'h0020);
        add(1, 5,  8'h56, 0, 0,  8'h00, 0, 0,  1, 1,  1, 5,  8'h56, 16'h0020);
        add(0, 0,  8'h00, 0, 0,  8'h00, 0, 0,  0, 1,  0, 5,  8'h56, 16'h0000);
        add(0, 0,  8'h00, 0, 0,  8'h00, 1, 0,  0, 1,  0, 5,  8'h56, 16'h0001);
        add(1, 0,  8'h01, 0, 0,  8'h00, 1, 15, 1, 1,  1, 0,  8'h01, 16'h8001);
        add(0, 0,  8'h00, 0, 0,  8'h00, 0, 0,  0, 1,  0, 0,  8'h01, 16'h8000);

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst_we",    16'(bus.WriteEn),   16'h0);
        chk("rst_waddr", 16'(bus.WriteAddr), 16'h0);
        chk("rst_wdata", 16'(bus.WriteData), 16'h0);
        chk("rst_busy",  bus.BusyVec,        16'h0);
        chk("rst_mr",    16'(bus.MemReady),  16'h1);
        chk("rst_ar",    16'(bus.AluReady),  16'h0);
`ifdef REGWB_STALL_CNT_EN
        chk("rst_stall", bus.StallCount,     16'h0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge Clk);
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md,
                  vecs[i].cv, vecs[i].ca);
            #1;
            chk($sformatf("v%0d_ar", i), 16'(bus.AluReady), 16'(vecs[i].ear));
            chk($sformatf("v%0d_mr", i), 16'(bus.MemReady), 16'(vecs[i].emr));
            @(posedge Clk);
            #1;
            chk($sformatf("v%0d_we", i),   16'(bus.WriteEn),   16'(vecs[i].ewe));
            chk($sformatf("v%0d_wa", i),   16'(bus.WriteAddr), 16'(vecs[i].ewa));
            chk($sformatf("v%0d_wd", i),   16'(bus.WriteData), 16'(vecs[i].ewd));
            chk($sformatf("v%0d_busy", i), bus.BusyVec,        vecs[i].ebusy);
        end

        // Build up two buffered loads with an ALU write in flight, then reset.
        @(negedge Clk);
        drive(1, 2, 8'h22, 1, 1, 8'h11, 0, 0);
        #1;
        chk("h_a_ar", 16'(bus.AluReady), 16'h1);
        @(posedge Clk);
        #1;
        chk("h_a_wa", 16'(bus.WriteAddr), 16'h2);
        @(negedge Clk);
        drive(1, 4, 8'h44, 1, 3, 8'h33, 0, 0);
        #1;
        chk("h_b_ar", 16'(bus.AluReady), 16'h0);
        @(posedge Clk);
        #1;
        chk("h_b_wd", 16'(bus.WriteData), 16'h11);
        @(negedge Clk);
        drive(1, 4, 8'h44, 1, 5, 8'h55, 0, 0);
        #1;
        chk("h_c_ar", 16'(bus.AluReady), 16'h1);
        chk("h_c_mr", 16'(bus.MemReady), 16'h1);
        @(posedge Clk);
        #1;
        chk("h_c_wd", 16'(bus.WriteData), 16'h44);
`ifdef REGWB_STALL_CNT_EN
        chk("h_c_stall", bus.StallCount, 16'd4);
`endif
        @(negedge Clk);
        Reset = 1'b1;
        drive(1, 6, 8'h66, 1, 6, 8'h66, 1, 7);
        #1;
        chk("h_d_mr_full", 16'(bus.MemReady), 16'h0);
        @(posedge Clk);
        #1;
        chk("h_d_we",   16'(bus.WriteEn), 16'h0);
        chk("h_d_busy", bus.BusyVec,      16'h0);
        @(negedge Clk);
        Reset = 1'b0;
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        #1;
        chk("h_e_mr", 16'(bus.MemReady), 16'h1);
        chk("h_e_ar", 16'(bus.AluReady), 16'h0);
`ifdef REGWB_STALL_CNT_EN
        chk("h_e_stall", bus.StallCount, 16'h0);
`endif
        @(posedge Clk);
        #1;
        chk("h_e_we",   16'(bus.WriteEn), 16'h0);
        chk("h_e_busy", bus.BusyVec,      16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
